// File: rtl/aoi_chk_pkg.sv
// Shared types and constants for the AOI response checker.
// The MISR constants are only consumed when AOI_CHK_MISR_EN is defined.
package aoi_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   // Golden model of the AOI cell: y = ~((a & b) | (c & d)).
   function automatic logic aoi_ref(input logic a, input logic b,
                                    input logic c, input logic d);
      return ~((a & b) | (c & d));
   endfunction

endpackage

// File: rtl/aoi_misr.sv
// 16-bit MISR (x^16+x^12+x^5+1) compacting {a,b,c,d,y} of each accepted vector.
// Instantiated by aoi_resp_checker only when AOI_CHK_MISR_EN is defined.
module aoi_misr
   import aoi_chk_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [4:0]  din,
   output logic [15:0] sig
);

   logic [15:0] sig_next;

   // Galois-form shift with feedback, then fold the new sample into the low bits.
   always_comb begin
      sig_next = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {11'b0, din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= MISR_SEED;
      end else if (clr) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= sig_next;
      end
   end

endmodule

// File: rtl/aoi_resp_checker.sv
// Response checker for the AOI cell: compares observed y against a reference model,
// counts vectors and errors, and records the first failure. Optional MISR: AOI_CHK_MISR_EN.
module aoi_resp_checker
   import aoi_chk_pkg::*;
#(
   parameter int NUM_VEC = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vld,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fail_seen,
   output logic [3:0]       first_fail_vec,
   output logic [CNT_W-1:0] first_fail_idx
`ifdef AOI_CHK_MISR_EN
   ,
   output logic [15:0]      signature
`endif
);

   chk_state_t state;
   chk_state_t state_next;

   logic take_start;
   logic accept;
   logic mismatch;
   logic last_vec;

   assign take_start = start && (state != RUN);
   assign accept     = vld && (state == RUN);
   assign mismatch   = (y != aoi_ref(a, b, c, d));
   assign last_vec   = (vec_cnt == CNT_W'(NUM_VEC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DONE only leaves on a fresh start; reset is the sole way back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && last_vec) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt        <= '0;
         err_cnt        <= '0;
         fail_seen      <= 1'b0;
         first_fail_vec <= 4'h0;
         first_fail_idx <= '0;
      end else if (take_start) begin
         vec_cnt        <= '0;
         err_cnt        <= '0;
         fail_seen      <= 1'b0;
         first_fail_vec <= 4'h0;
         first_fail_idx <= '0;
      end else if (accept) begin
         vec_cnt <= vec_cnt + CNT_W'(1);
         if (mismatch) begin
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
            if (!fail_seen) begin
               fail_seen      <= 1'b1;
               first_fail_vec <= {a, b, c, d};
               first_fail_idx <= vec_cnt;
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = done && (err_cnt == '0);

`ifdef AOI_CHK_MISR_EN
   aoi_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (take_start),
      .en    (accept),
      .din   ({a, b, c, d, y}),
      .sig   (signature)
   );
`endif

endmodule

// File: tb/tb_aoi_resp_checker.sv
// Directed self-checking bench for aoi_resp_checker (default and 3-bit saturation builds).
// Signature checks are compiled in only when AOI_CHK_MISR_EN is defined.
module tb_aoi_resp_checker;

   // Hand-derived AOI truth table, bit i = y for abcd = i.
   localparam logic [15:0] AOI_TABLE = 16'h0777;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start_s = 1'b0;
   logic vld = 1'b0;
   logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic y = 1'b0;
   logic y_s = 1'b0;

   logic       busy, done, pass, fail_seen;
   logic [7:0] vec_cnt, err_cnt, first_fail_idx;
   logic [3:0] first_fail_vec;

   logic       busy_s, done_s, pass_s, fail_seen_s;
   logic [2:0] vec_cnt_s, err_cnt_s, first_fail_idx_s;
   logic [3:0] first_fail_vec_s;

`ifdef AOI_CHK_MISR_EN
   logic [15:0] signature, signature_s;
`endif

   int errorCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   aoi_resp_checker #(.NUM_VEC(16), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
      .a(a), .b(b), .c(c), .d(d), .y(y),
      .busy(busy), .done(done), .pass(pass),
      .vec_cnt(vec_cnt), .err_cnt(err_cnt), .fail_seen(fail_seen),
      .first_fail_vec(first_fail_vec), .first_fail_idx(first_fail_idx)
`ifdef AOI_CHK_MISR_EN
      , .signature(signature)
`endif
   );

   aoi_resp_checker #(.NUM_VEC(7), .CNT_W(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .vld(vld),
      .a(a), .b(b), .c(c), .d(d), .y(y_s),
      .busy(busy_s), .done(done_s), .pass(pass_s),
      .vec_cnt(vec_cnt_s), .err_cnt(err_cnt_s), .fail_seen(fail_seen_s),
      .first_fail_vec(first_fail_vec_s), .first_fail_idx(first_fail_idx_s)
`ifdef AOI_CHK_MISR_EN
      , .signature(signature_s)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] abcd, input logic y_val, input logic y_s_val);
      {a, b, c, d} = abcd;
      y   = y_val;
      y_s = y_s_val;
      vld = 1'b1;
      tick();
      vld = 1'b0;
   endtask

   task automatic startRun();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sweep(input int fault_idx);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'(i), AOI_TABLE[i] ^ (i == fault_idx), 1'b0);
      end
   endtask

`ifdef AOI_CHK_MISR_EN
   function automatic logic [15:0] misrRun(input int fault_idx);
      logic [15:0] s;
      logic        yv;
      s = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         yv = AOI_TABLE[i] ^ (i == fault_idx);
         s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, 4'(i), yv};
      end
      return s;
   endfunction
`endif

   initial begin
      $display("[TB] aoi_resp_checker directed bench");

      // Reset state
      tick(); tick(); tick();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_pass", pass, 0);
      checkOutput("rst_vec_cnt", vec_cnt, 0);
      checkOutput("rst_err_cnt", err_cnt, 0);
      checkOutput("rst_fail_seen", fail_seen, 0);
      checkOutput("rst_ffv", first_fail_vec, 0);
      checkOutput("rst_ffi", first_fail_idx, 0);
      rst_n = 1'b1;
      tick();

      // Gaps and ignored inputs
      applyStimulus(4'd3, 1'b1, 1'b1);
      applyStimulus(4'd12, 1'b1, 1'b1);
      checkOutput("idle_vld_vec_cnt", vec_cnt, 0);
      checkOutput("idle_vld_err_cnt", err_cnt, 0);
      checkOutput("idle_vld_busy", busy, 0);
      checkOutput("idle_vld_vec_cnt_s", vec_cnt_s, 0);
      start = 1'b1; vld = 1'b1; {a, b, c, d} = 4'd0; y = 1'b0;
      tick();
      start = 1'b0; vld = 1'b0;
      checkOutput("start_vld_busy", busy, 1);
      checkOutput("start_vld_vec_cnt", vec_cnt, 0);
      checkOutput("start_vld_err_cnt", err_cnt, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'(i), AOI_TABLE[i], 1'b0);
         if (i == 4) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            checkOutput("run_start_ignored_vec", vec_cnt, 5);
            checkOutput("run_start_ignored_busy", busy, 1);
         end else begin
            tick();
         end
         if (i == 14) begin
            checkOutput("gap_not_done_15", done, 0);
            checkOutput("gap_vec_cnt_15", vec_cnt, 15);
         end
      end
      checkOutput("gap_done", done, 1);
      checkOutput("gap_pass", pass, 1);
      checkOutput("gap_vec_cnt", vec_cnt, 16);

      // Exhaustive clean run, restarted from DONE
      startRun();
      checkOutput("restart_vec_cnt", vec_cnt, 0);
      checkOutput("restart_busy", busy, 1);
      checkOutput("restart_done", done, 0);
`ifdef AOI_CHK_MISR_EN
      checkOutput("restart_sig_seed", signature, 16'hFFFF);
`endif
      for (int i = 0; i < 16; i++) begin
         if (i == 15) checkOutput("full_not_done_early", done, 0);
         applyStimulus(4'(i), AOI_TABLE[i], 1'b0);
      end
      checkOutput("full_done", done, 1);
      checkOutput("full_pass", pass, 1);
      checkOutput("full_busy", busy, 0);
      checkOutput("full_vec_cnt", vec_cnt, 16);
      checkOutput("full_err_cnt", err_cnt, 0);
      checkOutput("full_fail_seen", fail_seen, 0);
`ifdef AOI_CHK_MISR_EN
      checkOutput("sig_clean_1", signature, misrRun(-1));
      startRun();
      sweep(-1);
      checkOutput("sig_clean_2", signature, misrRun(-1));
      checkOutput("full2_pass", pass, 1);
`endif

      // Single injected fault at index 5
      startRun();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'(i), AOI_TABLE[i] ^ (i == 5), 1'b0);
         if (i == 5) begin
            checkOutput("fault_mid_fail_seen", fail_seen, 1);
            checkOutput("fault_mid_err_cnt", err_cnt, 1);
         end
      end
      checkOutput("fault_err_cnt", err_cnt, 1);
      checkOutput("fault_fail_seen", fail_seen, 1);
      checkOutput("fault_ffv", first_fail_vec, 4'b0101);
      checkOutput("fault_ffi", first_fail_idx, 5);
      checkOutput("fault_done", done, 1);
      checkOutput("fault_pass", pass, 0);
      checkOutput("fault_vec_cnt", vec_cnt, 16);
`ifdef AOI_CHK_MISR_EN
      checkOutput("sig_fault", signature, misrRun(5));
      checkOutput("sig_fault_differs", signature != misrRun(-1), 1);
`endif

      // Saturation on the 3-bit instance
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      checkOutput("sat_busy", busy_s, 1);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) checkOutput("sat_not_done_early", done_s, 0);
         applyStimulus(4'(i), AOI_TABLE[i], ~AOI_TABLE[i]);
      end
      checkOutput("sat_err_cnt", err_cnt_s, 7);
      checkOutput("sat_vec_cnt", vec_cnt_s, 7);
      checkOutput("sat_ffi", first_fail_idx_s, 0);
      checkOutput("sat_ffv", first_fail_vec_s, 0);
      checkOutput("sat_done", done_s, 1);
      checkOutput("sat_pass", pass_s, 0);
      checkOutput("sat_main_untouched", err_cnt, 1);

      // Asynchronous reset mid-run, then a clean sweep
      startRun();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(4'(i), AOI_TABLE[i] ^ (i == 2), 1'b0);
      end
      checkOutput("pre_rst_vec_cnt", vec_cnt, 9);
      checkOutput("pre_rst_ffi", first_fail_idx, 2);
      rst_n = 1'b0;
      #2;
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_done", done, 0);
      checkOutput("arst_vec_cnt", vec_cnt, 0);
      checkOutput("arst_err_cnt", err_cnt, 0);
      checkOutput("arst_fail_seen", fail_seen, 0);
      checkOutput("arst_ffv", first_fail_vec, 0);
      checkOutput("arst_ffi", first_fail_idx, 0);
      checkOutput("arst_done_s", done_s, 0);
`ifdef AOI_CHK_MISR_EN
      checkOutput("arst_sig", signature, 16'hFFFF);
`endif
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_idle", busy, 0);
      startRun();
      sweep(-1);
      checkOutput("post_rst_pass", pass, 1);
      checkOutput("post_rst_vec_cnt", vec_cnt, 16);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/aoi_resp_checker.md
Name: aoi_resp_checker

Overview:
- Response-side checker for the AOI cell (y = ~((a&b)|(c&d))). It is the receiving end of the AOI stimulus stream.
- It samples each applied vector {a,b,c,d} together with the DUT output y and compares y against a built-in reference model.
- It counts vectors and mismatches, and records the first failing vector.
- It sits beside the AOI instance in self-checking benches and on-chip BIST wrappers, replacing manual waveform inspection.

Parameters:
- NUM_VEC, 16, number of vectors per run; legal range 1..(2^CNT_W - 1).
- CNT_W, 8, width of the vector and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- vld  in  1  a, b, c, d and y are valid this cycle.
- a  in  1  applied AOI input a.
- b  in  1  applied AOI input b.
- c  in  1  applied AOI input c.
- d  in  1  applied AOI input d.
- y  in  1  observed AOI output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; level, not pulse.
- pass  out  1  done && (err_cnt == 0).
- vec_cnt  out  CNT_W  vectors accepted in the current run.
- err_cnt  out  CNT_W  mismatches in the current run; saturating.
- fail_seen  out  1  at least one mismatch in the current run.
- first_fail_vec  out  4  {a,b,c,d} of the first mismatch.
- first_fail_idx  out  CNT_W  vec_cnt value at the first mismatch (0-based).

Behaviour:
- Reset values: all outputs are 0, and the FSM is in IDLE. Reset is asynchronous and takes effect immediately, including mid-run.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start. The same edge clears vec_cnt, err_cnt, fail_seen, first_fail_vec and first_fail_idx.
- RUN -> DONE on the edge that accepts vector number NUM_VEC, i.e. when vec_cnt == NUM_VEC-1 && vld.
- DONE -> RUN on start, with the same clears as IDLE -> RUN. DONE has no other exit; only rst_n returns the FSM to IDLE.
- start in RUN is ignored.
- vld in IDLE or DONE is ignored; no counter changes.
- Vectors are accepted in RUN only, and only on cycles with vld=1.
  - expected = ~((a&b)|(c&d)), computed combinationally from the same-cycle inputs.
  - vec_cnt increments by 1.
  - If y != expected:
    - err_cnt increments, saturating at 2^CNT_W-1.
    - If fail_seen==0: first_fail_vec <= {a,b,c,d}, first_fail_idx <= current vec_cnt, fail_seen <= 1.
- Latency: all outputs are registered. The effect of a vector accepted on edge N is visible after edge N.
  - done/pass assert in the cycle after the final vld.
- Gaps (vld=0) in RUN are allowed; nothing changes.
- start and vld in the same cycle in IDLE/DONE: start is taken, and that vld is not counted.
- Reset mid-run discards all results; outputs return to 0.

Optional Feature:
- Macro: AOI_CHK_MISR_EN.
- When defined:
  - Adds output signature [15:0], a 16-bit MISR with polynomial x^16+x^12+x^5+1.
  - Seeded to 16'hFFFF on reset and on an accepted start.
  - On each accepted vector, shifts once and XORs {11'b0,a,b,c,d,y} into bits [4:0].
  - Frozen in IDLE and DONE.
- When undefined: the signature port and the MISR logic are absent. All other behaviour is identical.

Decomposition:
- Package aoi_chk_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - function aoi_ref(a,b,c,d);
  - constants MISR_POLY=16'h1021 and MISR_SEED=16'hFFFF.
- Sub-module aoi_misr (clk, rst_n, clr, en, din[4:0], sig[15:0]) is natural. It is instantiated only under AOI_CHK_MISR_EN.

Test Plan:
- Exhaustive correct run: start, then 16 vld cycles with abcd=0..15 and y=aoi_ref.
  - Required: done=1, pass=1, vec_cnt=16, err_cnt=0, fail_seen=0, one cycle after the 16th vld.
- Single injected fault: same sweep, but at abcd=4'b0101 (index 5, expected 1) drive y=0.
  - Required: err_cnt=1, fail_seen=1, first_fail_vec=4'b0101, first_fail_idx=5, pass=0.
- Saturation: CNT_W=3, NUM_VEC=7, all 7 vectors with y inverted.
  - Required: err_cnt=7 (no wrap), first_fail_idx=0, done=1, pass=0.
- Gaps and ignored inputs: vld pulses while IDLE, start pulsed mid-RUN, vld low on alternate cycles.
  - Required: pre-start vectors are not counted, the run is not restarted, and done follows exactly NUM_VEC accepted vectors.
- Reset and restart:
  - Assert rst_n=0 after vector 9 of 16. Required: all outputs 0 asynchronously, FSM in IDLE.
  - Then run a full clean sweep. Required: pass=1.
  - A start in DONE clears the counters and restarts.
- With AOI_CHK_MISR_EN: repeat the exhaustive correct run twice.
  - Required: identical signature both times.
  - Required: the single-fault run yields a different signature.
